// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480 raster timing with a 2x-scaled, double-buffered frame fetch.
// Swaps the displayed buffer with the game logic at the start of vblank.
module vga_scan_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 2,
    parameter int MEM_LAT  = 2,
    parameter int ADDR_W   = 18
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pix_en,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [3:0]        i_rd_data,
    output logic [3:0]        o_pix_idx,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_blank_n,
    output logic              o_frame_start,
    input  logic              i_swap_req,
    output logic              o_swap_ack,
    output logic              o_disp_buf
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_W = H_ACTIVE / SCALE;
    localparam int FB_H = V_ACTIVE / SCALE;
    localparam int PW = SCALE > 1 ? $clog2(SCALE) : 1;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [PW-1:0] PH_LAST = PW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] SX_LAST = ADDR_W'(FB_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);

    typedef enum logic {IDLE, PEND} swap_t;

    swap_t             state_q, state_d;
    logic [9:0]        h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [PW-1:0]     hph_q, hph_d, vph_q, vph_d;
    logic [ADDR_W-1:0] sx_q, sx_d, row_base_q, row_base_d, rd_addr_q, rd_addr_d;
    logic [MEM_LAT:0]  vis_sr_q, vis_sr_d, hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;
    logic [3:0]        pix_idx_q, pix_idx_d;
    logic              blank_n_q, blank_n_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic              frame_start_q, frame_start_d, swap_ack_q, swap_ack_d, disp_buf_q, disp_buf_d;
    logic              tick_vis, h_wrap, vb_start;

    always_comb begin
        tick_vis = h_cnt_q < H_ACT && v_cnt_q < V_ACT;
        h_wrap = h_cnt_q == H_LAST;
        vb_start = i_pix_en && h_cnt_q == 10'd0 && v_cnt_q == V_ACT;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        hph_d = hph_q;
        vph_d = vph_q;
        sx_d = sx_q;
        row_base_d = row_base_q;
        rd_addr_d = rd_addr_q;
        vis_sr_d = vis_sr_q;
        hs_sr_d = hs_sr_q;
        vs_sr_d = vs_sr_q;
        pix_idx_d = pix_idx_q;
        blank_n_d = blank_n_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        frame_start_d = 1'b0;
        swap_ack_d = 1'b0;
        disp_buf_d = disp_buf_q;
        state_d = state_q;
        if (i_pix_en) begin
            h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
            if (h_wrap)
                v_cnt_d = v_cnt_q == V_LAST ? 10'd0 : v_cnt_q + 10'd1;
            if (tick_vis) begin
                hph_d = hph_q == PH_LAST ? PW'(0) : hph_q + PW'(1);
                if (hph_q == PH_LAST)
                    sx_d = sx_q == SX_LAST ? '0 : sx_q + ADDR_W'(1);
                rd_addr_d = (disp_buf_q ? FB_SIZE : '0) + row_base_q + sx_q;
            end
            // Each framebuffer row is shown on SCALE consecutive visible lines.
            if (h_wrap && v_cnt_q == V_LAST) begin
                row_base_d = '0;
                vph_d = '0;
            end else if (h_wrap && v_cnt_q < V_ACT) begin
                vph_d = vph_q == PH_LAST ? PW'(0) : vph_q + PW'(1);
                if (vph_q == PH_LAST)
                    row_base_d = row_base_q + ROW_STEP;
            end
            vis_sr_d = {vis_sr_q[MEM_LAT-1:0], tick_vis};
            hs_sr_d = {hs_sr_q[MEM_LAT-1:0], !(h_cnt_q >= HS_START && h_cnt_q < HS_END)};
            vs_sr_d = {vs_sr_q[MEM_LAT-1:0], !(v_cnt_q >= VS_START && v_cnt_q < VS_END)};
            pix_idx_d = vis_sr_q[MEM_LAT] ? i_rd_data : 4'd0;
            blank_n_d = vis_sr_q[MEM_LAT];
            hsync_d = hs_sr_q[MEM_LAT];
            vsync_d = vs_sr_q[MEM_LAT];
            frame_start_d = h_cnt_q == 10'd0 && v_cnt_q == 10'd0;
        end
        if (vb_start && (state_q == PEND || i_swap_req)) begin
            disp_buf_d = !disp_buf_q;
            swap_ack_d = 1'b1;
            state_d = IDLE;
        end else if (i_swap_req) begin
            state_d = PEND;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hph_q <= '0;
            vph_q <= '0;
            sx_q <= '0;
            row_base_q <= '0;
            rd_addr_q <= '0;
            vis_sr_q <= '0;
            hs_sr_q <= '1;
            vs_sr_q <= '1;
            pix_idx_q <= '0;
            blank_n_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            frame_start_q <= 1'b0;
            swap_ack_q <= 1'b0;
            disp_buf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hph_q <= hph_d;
            vph_q <= vph_d;
            sx_q <= sx_d;
            row_base_q <= row_base_d;
            rd_addr_q <= rd_addr_d;
            vis_sr_q <= vis_sr_d;
            hs_sr_q <= hs_sr_d;
            vs_sr_q <= vs_sr_d;
            pix_idx_q <= pix_idx_d;
            blank_n_q <= blank_n_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            frame_start_q <= frame_start_d;
            swap_ack_q <= swap_ack_d;
            disp_buf_q <= disp_buf_d;
        end
    end

    assign o_rd_en = vis_sr_q[0];
    assign o_rd_addr = rd_addr_q;
    assign o_pix_idx = pix_idx_q;
    assign o_hsync = hsync_q;
    assign o_vsync = vsync_q;
    assign o_blank_n = blank_n_q;
    assign o_frame_start = frame_start_q;
    assign o_swap_ack = swap_ack_q;
    assign o_disp_buf = disp_buf_q;
endmodule
